// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults (640x480@60), the sync bundle type and a width helper
// for the VGA raster timing generator.
package vga_timing_gen_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Signals that travel together through the optional latency-matching stages.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    // Bits needed to count 0..value-1; never less than one.
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width++;
            rem = rem >> 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH=0 is a plain wire.
// Every stage resets to RST_VAL so delayed syncs come out inactive.
module vga_delay_line #(
    parameter int                WIDTH   = 1,
    parameter int                DEPTH   = 0,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk_i, rst_ni, en_i};
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            // NOTE: this small array is reset on purpose (unlike a RAM) because its
            // contents reach the DAC pins straight out of reset.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, H/V counters,
// registered sync/blank/coordinate decode and a per-frame display-buffer swap.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int PIPE     = 0
) (
    input  logic           real100clock,
    input  logic           resetN,
    output logic           pixelEn,
    output logic           VGAclock,
    output logic           hsync,
    output logic           vsync,
    output logic           VGAblank,
    output logic           VGAsync,
    output logic [X_W-1:0] xPixel,
    output logic [Y_W-1:0] yPixel,
    output logic           frameStart,
    output logic           lineStart,
    input  logic           swapReq,
    output logic           swapAck,
    output logic           bufSel
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = clog2(H_TOTAL);
    localparam int V_W     = clog2(V_TOTAL);
    localparam int DIV_W   = clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    // One extra bit so a sync window ending exactly at a power of two still fits.
    localparam logic [H_W:0]     H_ACT    = (H_W+1)'(H_ACTIVE);
    localparam logic [H_W:0]     HS_START = (H_W+1)'(H_ACTIVE + H_FP);
    localparam logic [H_W:0]     HS_END   = (H_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W:0]     V_ACT    = (V_W+1)'(V_ACTIVE);
    localparam logic [V_W:0]     VS_START = (V_W+1)'(V_ACTIVE + V_FP);
    localparam logic [V_W:0]     VS_END   = (V_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam sync_t            SYNC_RST = '{hsync: ~HS_POL, vsync: ~VS_POL, blank: 1'b0};

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("vga_timing_gen: CLK_DIV must be at least 2");
        end
        if (H_ACTIVE > (1 << X_W)) begin : g_bad_x_w
            $error("vga_timing_gen: X_W too narrow for H_ACTIVE");
        end
        if (V_ACTIVE > (1 << Y_W)) begin : g_bad_y_w
            $error("vga_timing_gen: Y_W too narrow for V_ACTIVE");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_en_q, vga_clk_q;
    logic [H_W-1:0]   h_cnt_q, h_cnt_d;
    logic [V_W-1:0]   v_cnt_q, v_cnt_d;
    logic [H_W:0]     h_ext;
    logic [V_W:0]     v_ext;
    logic             h_vis, v_vis, swap_take;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    sync_t            sync_q, sync_d, sync_out;
    logic             frame_start_q, line_start_q, swap_ack_q, buf_sel_q;

    assign h_ext = {1'b0, h_cnt_q};
    assign v_ext = {1'b0, v_cnt_q};

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Decode of the current counter position; loaded on pixelEn, so one pixel late.
    always_comb begin
        h_vis        = (h_ext < H_ACT);
        v_vis        = (v_ext < V_ACT);
        sync_d.hsync = (h_ext >= HS_START && h_ext < HS_END) ? HS_POL : ~HS_POL;
        sync_d.vsync = (v_ext >= VS_START && v_ext < VS_END) ? VS_POL : ~VS_POL;
        sync_d.blank = h_vis && v_vis;
        x_d          = h_vis ? X_W'(h_cnt_q) : '0;
        y_d          = v_vis ? Y_W'(v_cnt_q) : '0;
        swap_take    = pix_en_q && (h_cnt_q == '0) && (v_ext == V_ACT) && swapReq;
    end

    // NOTE: every register here is written with <= so all of them sample the
    // pre-edge counter values, which is what keeps the decode exactly one pixel behind.
    always_ff @(posedge real100clock) begin
        if (!resetN) begin
            div_cnt_q     <= '0;
            pix_en_q      <= 1'b0;
            vga_clk_q     <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            sync_q        <= SYNC_RST;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            swap_ack_q    <= 1'b0;
            buf_sel_q     <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_en_q      <= (div_cnt_q == DIV_LAST);
            vga_clk_q     <= (div_cnt_q >= DIV_HALF);
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            swap_ack_q    <= swap_take;
            if (swap_take) buf_sel_q <= ~buf_sel_q;
            if (pix_en_q) begin
                x_q           <= x_d;
                y_q           <= y_d;
                sync_q        <= sync_d;
                frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
                line_start_q  <= (h_cnt_q == '0);
            end
        end
    end

    vga_delay_line #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (PIPE),
        .RST_VAL (SYNC_RST)
    ) u_sync_delay (
        .clk_i  (real100clock),
        .rst_ni (resetN),
        .en_i   (pix_en_q),
        .d_i    (sync_q),
        .q_o    (sync_out)
    );

    assign pixelEn    = pix_en_q;
    assign VGAclock   = vga_clk_q;
    assign hsync      = sync_out.hsync;
    assign vsync      = sync_out.vsync;
    assign VGAblank   = sync_out.blank;
    assign VGAsync    = 1'b0;
    assign xPixel     = x_q;
    assign yPixel     = y_q;
    assign frameStart = frame_start_q;
    assign lineStart  = line_start_q;
    assign swapAck    = swap_ack_q;
    assign bufSel     = buf_sel_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 16x8 raster (24x13 total) so whole frames
// fit in a short run; a second instance covers CLK_DIV=4, PIPE=2, active-high syncs.
module tb_vga_timing_gen;

    localparam int HT = 24;
    localparam int VT = 13;

    logic clk = 1'b0;
    logic reset_n;
    logic swap_req;
    int   cyc;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       pe_a, vc_a, hs_a, vs_a, bl_a, vsy_a, fs_a, ls_a, ack_a, buf_a;
    logic [3:0] x_a;
    logic [2:0] y_a;
    logic       pe_b, vc_b, hs_b, vs_b, bl_b, vsy_b, fs_b, ls_b, ack_b, buf_b;
    logic [3:0] x_b;
    logic [2:0] y_b;

    always #5 clk = ~clk;

    // Ref cycles since reset release; equals t at the negedge after edge t.
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .X_W(4), .Y_W(3), .PIPE(0)
    ) u_dut_a (
        .real100clock(clk), .resetN(reset_n), .pixelEn(pe_a), .VGAclock(vc_a),
        .hsync(hs_a), .vsync(vs_a), .VGAblank(bl_a), .VGAsync(vsy_a),
        .xPixel(x_a), .yPixel(y_a), .frameStart(fs_a), .lineStart(ls_a),
        .swapReq(swap_req), .swapAck(ack_a), .bufSel(buf_a)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .X_W(4), .Y_W(3), .PIPE(2)
    ) u_dut_b (
        .real100clock(clk), .resetN(reset_n), .pixelEn(pe_b), .VGAclock(vc_b),
        .hsync(hs_b), .vsync(vs_b), .VGAblank(bl_b), .VGAsync(vsy_b),
        .xPixel(x_b), .yPixel(y_b), .frameStart(fs_b), .lineStart(ls_b),
        .swapReq(1'b0), .swapAck(ack_b), .bufSel(buf_b)
    );

    typedef struct {
        int h; int v;
        int x; int y;
        bit hs; bit vs; bit bl; bit ls; bit fs;
    } vec_t;

    typedef struct {
        int   t;
        int   idx;
        vec_t e;
    } sb_t;

    vec_t vecs [19];
    sb_t  sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard consumer: compares each expected decode in the ref cycle it appears.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].t == cyc) begin
            check($sformatf("vec%0d_x", sb[0].idx),  x_a,  sb[0].e.x);
            check($sformatf("vec%0d_y", sb[0].idx),  y_a,  sb[0].e.y);
            check($sformatf("vec%0d_hs", sb[0].idx), hs_a, sb[0].e.hs);
            check($sformatf("vec%0d_vs", sb[0].idx), vs_a, sb[0].e.vs);
            check($sformatf("vec%0d_bl", sb[0].idx), bl_a, sb[0].e.bl);
            check($sformatf("vec%0d_ls", sb[0].idx), ls_a, sb[0].e.ls);
            check($sformatf("vec%0d_fs", sb[0].idx), fs_a, sb[0].e.fs);
            void'(sb.pop_front());
        end
    end

    task automatic swap_window(input string name, input int t_end, input bit drop_on_ack,
                               input int t_drop, input int n_exp, input int first_exp,
                               input int last_exp, input bit buf_exp);
        int n;
        int first;
        int last;
        n = 0;
        first = -1;
        last = -1;
        while (cyc < t_end) begin
            @(negedge clk);
            if (ack_a === 1'b1) begin
                n++;
                if (first < 0) first = cyc;
                last = cyc;
                if (drop_on_ack) swap_req = 1'b0;
            end
            if (cyc == t_drop) swap_req = 1'b0;
        end
        check({name, "_acks"}, n, n_exp);
        if (n_exp > 0) begin
            check({name, "_first_ack_cycle"}, first, first_exp);
            check({name, "_last_ack_cycle"}, last, last_exp);
        end
        check({name, "_bufsel"}, buf_a, buf_exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // h, v, x, y, hs, vs, bl, ls, fs  (syncs active-low)
        vecs[0]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
        vecs[1]  = '{1, 0, 1, 0, 1, 1, 1, 0, 0};
        vecs[2]  = '{15, 0, 15, 0, 1, 1, 1, 0, 0};
        vecs[3]  = '{16, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[4]  = '{17, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[5]  = '{18, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[6]  = '{20, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{21, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[8]  = '{23, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, 1, 1, 1, 1, 1, 0};
        vecs[10] = '{7, 3, 7, 3, 1, 1, 1, 0, 0};
        vecs[11] = '{15, 7, 15, 7, 1, 1, 1, 0, 0};
        vecs[12] = '{0, 8, 0, 0, 1, 1, 0, 1, 0};
        vecs[13] = '{19, 8, 0, 0, 0, 1, 0, 0, 0};
        vecs[14] = '{0, 9, 0, 0, 1, 0, 0, 1, 0};
        vecs[15] = '{20, 10, 0, 0, 0, 0, 0, 0, 0};
        vecs[16] = '{0, 11, 0, 0, 1, 1, 0, 1, 0};
        vecs[17] = '{23, 12, 0, 0, 1, 1, 0, 0, 0};
        vecs[18] = '{0, 13, 0, 0, 1, 1, 1, 1, 1};

        reset_n  = 1'b0;
        swap_req = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_pixelEn", pe_a, 0);
        check("rst_VGAclock", vc_a, 0);
        check("rst_hsync", hs_a, 1);
        check("rst_vsync", vs_a, 1);
        check("rst_blank", bl_a, 0);
        check("rst_VGAsync", vsy_a, 0);
        check("rst_x", x_a, 0);
        check("rst_y", y_a, 0);
        check("rst_frameStart", fs_a, 0);
        check("rst_lineStart", ls_a, 0);
        check("rst_swapAck", ack_a, 0);
        check("rst_bufSel", buf_a, 0);
        check("rst_b_hsync", hs_b, 0);
        check("rst_b_vsync", vs_b, 0);
        check("rst_b_blank", bl_b, 0);
        reset_n = 1'b1;

        fork
            begin : main_a
                // Pixel P's decode is visible from ref cycle (P+1)*2+1.
                for (int i = 0; i < 19; i++)
                    sb.push_back('{((vecs[i].v * HT + vecs[i].h) + 1) * 2 + 1, i, vecs[i]});
                for (int t = 1; t <= 6; t++) begin
                    wait_until(t);
                    check($sformatf("a_pixelEn_t%0d", t), pe_a, (t % 2 == 0));
                    check($sformatf("a_VGAclock_t%0d", t), vc_a, (t % 2 == 0));
                end
                while (sb.size() > 0 && cyc < 700) @(negedge clk);
                check("scoreboard_drained", sb.size(), 0);

                // Frame f decision (h=0, v=8) is visible at ((f*312+192)+1)*2+1.
                wait_until(700);
                swap_req = 1'b1;
                swap_window("swap_once", 1700, 1'b1, -1, 1, 1011, 1011, 1'b1);
                swap_req = 1'b1;
                swap_window("swap_cancel", 2300, 1'b0, 2200, 0, 0, 0, 1'b1);
                swap_req = 1'b1;
                swap_window("swap_held", 3600, 1'b0, 3510, 2, 2883, 3507, 1'b1);
                wait_until(4130);
                swap_req = 1'b1;
                swap_window("swap_rise_on_decision", 4200, 1'b1, -1, 1, 4131, 4131, 1'b0);
                wait_until(4500);
                swap_req = 1'b1;
                swap_window("swap_frame7", 4800, 1'b0, -1, 1, 4755, 4755, 1'b1);

                wait_until(5245);
                check("pre_reset_x", x_a, 5);
                check("pre_reset_y", y_a, 5);
                check("pre_reset_bufSel", buf_a, 1);
                reset_n  = 1'b0;
                swap_req = 1'b0;
                @(negedge clk);
                check("midrst_x", x_a, 0);
                check("midrst_y", y_a, 0);
                check("midrst_blank", bl_a, 0);
                check("midrst_hsync", hs_a, 1);
                check("midrst_vsync", vs_a, 1);
                check("midrst_pixelEn", pe_a, 0);
                check("midrst_bufSel", buf_a, 0);
                check("midrst_swapAck", ack_a, 0);
                reset_n = 1'b1;
                wait_until(2);
                check("restart_fs_early", fs_a, 0);
                wait_until(3);
                check("restart_fs", fs_a, 1);
                check("restart_blank", bl_a, 1);
                swap_window("after_reset", 450, 1'b0, -1, 0, 0, 0, 1'b0);
            end
            begin : pipe_b
                for (int t = 1; t <= 8; t++) begin
                    wait_until(t);
                    check($sformatf("b_pixelEn_t%0d", t), pe_b, (t % 4 == 0));
                    check($sformatf("b_VGAclock_t%0d", t), vc_b, ((t - 1) % 4 >= 2));
                end
                wait_until(164); check("b_x_last_active", x_b, 15);
                wait_until(165); check("b_x_front_porch", x_b, 0);
                wait_until(172); check("b_blank_before", bl_b, 1);
                wait_until(173); check("b_blank_fall", bl_b, 0);
                wait_until(180); check("b_hsync_before", hs_b, 0);
                wait_until(181); check("b_hsync_rise", hs_b, 1);
                wait_until(192); check("b_hsync_last", hs_b, 1);
                wait_until(193); check("b_hsync_fall", hs_b, 0);
                wait_until(876); check("b_vsync_before", vs_b, 0);
                wait_until(877); check("b_vsync_rise", vs_b, 1);
            end
            begin : frame_counts
                int n_vs;
                int n_hs;
                int n_bl;
                int n_fs;
                int n_ls;
                n_vs = 0; n_hs = 0; n_bl = 0; n_fs = 0; n_ls = 0;
                wait_until(627);
                repeat (HT * VT * 2) begin
                    if (pe_a && !vs_a) n_vs++;
                    if (pe_a && !hs_a) n_hs++;
                    if (pe_a && bl_a) n_bl++;
                    if (fs_a) n_fs++;
                    if (ls_a) n_ls++;
                    @(negedge clk);
                end
                check("frame_vsync_low_pixels", n_vs, 48);
                check("frame_hsync_low_pixels", n_hs, 39);
                check("frame_visible_pixels", n_bl, 128);
                check("frame_frameStart_cycles", n_fs, 1);
                check("frame_lineStart_cycles", n_ls, 13);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
